// File: rtl/fir_coeff_sequencer.sv
// Sequencer in front of the FIR core: multiplexes the FIR input bus between the
// sample stream and coefficient loads, draining the in-flight sample before a load.
module fir_coeff_sequencer #(
  parameter int unsigned DATA_W       = 6,
  parameter int unsigned NUM_TAPS     = 4,
  parameter int unsigned IDLE_TIMEOUT = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cfg_req,
  input  logic [NUM_TAPS*DATA_W-1:0]   cfg_coeff,
  output logic                         cfg_ack,
  output logic                         cfg_busy,
  input  logic [DATA_W-1:0]            s_in_tdata,
  input  logic                         s_in_tvalid,
  output logic                         s_in_tready,
  output logic [DATA_W-1:0]            fir_tdata,
  output logic                         fir_tvalid,
  output logic                         fir_set_coeffs,
  input  logic                         fir_tready,
  output logic [1:0]                   state_o
);

  localparam int unsigned COEFF_W = NUM_TAPS * DATA_W;
  localparam int unsigned TAP_W   = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
  localparam int unsigned CNT_W   = $clog2(IDLE_TIMEOUT + 1);

  localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(NUM_TAPS - 1);
  localparam logic [CNT_W-1:0] TIMEOUT  = CNT_W'(IDLE_TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_STREAM = 2'b01,
    ST_DRAIN  = 2'b10,
    ST_LOAD   = 2'b11
  } state_t;

  state_t               state_q, state_d;
  logic [TAP_W-1:0]     tap_q, tap_d, tap_nxt;
  logic [CNT_W-1:0]     idle_cnt_q, idle_cnt_d;
  logic [COEFF_W-1:0]   shadow_q, shadow_d;
  logic [DATA_W-1:0]    data_q, data_d, coeff_sel;
  logic                 valid_q, valid_d;
  logic                 set_q, set_d;
  logic                 ack_q, ack_d;
  logic                 sample_take;

  // Upstream may hand over a sample only while streaming, with no load pending and a free beat slot
  assign s_in_tready    = (state_q == ST_STREAM) && !cfg_req && (!valid_q || fir_tready);
  assign sample_take    = s_in_tvalid && s_in_tready;

  assign fir_tdata      = data_q;
  assign fir_tvalid     = valid_q;
  assign fir_set_coeffs = set_q;
  assign cfg_ack        = ack_q;
  assign cfg_busy       = (state_q == ST_DRAIN) || (state_q == ST_LOAD);
  assign state_o        = state_q;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, beat register and counter update
  always_comb begin
    state_d    = state_q;
    tap_d      = tap_q;
    idle_cnt_d = idle_cnt_q;
    shadow_d   = shadow_q;
    data_d     = data_q;
    valid_d    = valid_q;
    set_d      = set_q;
    ack_d      = 1'b0;
    tap_nxt    = tap_q + TAP_W'(1);
    coeff_sel  = '0;

    for (int unsigned i = 0; i < NUM_TAPS; i++) begin
      if (tap_nxt == TAP_W'(i)) begin
        coeff_sel = shadow_q[i*DATA_W +: DATA_W];
      end
    end

    // An accepted beat retires; a state below may replace it on the same edge
    if (valid_q && fir_tready) begin
      valid_d = 1'b0;
      set_d   = 1'b0;
      data_d  = '0;
    end

    unique case (state_q)
      ST_IDLE: begin
        idle_cnt_d = '0;
        tap_d      = '0;
        if (cfg_req) begin
          state_d  = ST_LOAD;
          shadow_d = cfg_coeff;
          data_d   = cfg_coeff[DATA_W-1:0];
          valid_d  = 1'b1;
          set_d    = 1'b1;
        end else if (s_in_tvalid) begin
          state_d = ST_STREAM;
        end
      end

      ST_STREAM: begin
        if (cfg_req) begin
          state_d    = ST_DRAIN;
          idle_cnt_d = '0;
        end else begin
          if (sample_take) begin
            data_d  = s_in_tdata;
            valid_d = 1'b1;
            set_d   = 1'b0;
          end
          if (s_in_tvalid) begin
            idle_cnt_d = '0;
          end else if (idle_cnt_q != TIMEOUT) begin
            idle_cnt_d = idle_cnt_q + CNT_W'(1);
          end
          if (!s_in_tvalid && (idle_cnt_d == TIMEOUT) && !valid_q) begin
            state_d    = ST_IDLE;
            idle_cnt_d = '0;
          end
        end
      end

      ST_DRAIN: begin
        // Leave as soon as the pending sample is gone or retiring this edge
        if (!valid_q || fir_tready) begin
          state_d  = ST_LOAD;
          shadow_d = cfg_coeff;
          tap_d    = '0;
          data_d   = cfg_coeff[DATA_W-1:0];
          valid_d  = 1'b1;
          set_d    = 1'b1;
        end
      end

      ST_LOAD: begin
        idle_cnt_d = '0;
        if (valid_q && fir_tready) begin
          if (tap_q == TAP_LAST) begin
            ack_d   = 1'b1;
            tap_d   = '0;
            state_d = s_in_tvalid ? ST_STREAM : ST_IDLE;
          end else begin
            tap_d   = tap_nxt;
            data_d  = coeff_sel;
            valid_d = 1'b1;
            set_d   = 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Datapath and counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tap_q      <= '0;
      idle_cnt_q <= '0;
      shadow_q   <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      set_q      <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      tap_q      <= tap_d;
      idle_cnt_q <= idle_cnt_d;
      shadow_q   <= shadow_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      set_q      <= set_d;
      ack_q      <= ack_d;
    end
  end

endmodule

// File: tb/tb_fir_coeff_sequencer.sv
// Bench for fir_coeff_sequencer: directed scenarios plus a random phase, with a
// transaction scoreboard of expected FIR beats (samples in order, coefficient taps).
module tb_fir_coeff_sequencer;

  localparam int unsigned DW = 6;
  localparam int unsigned NT = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              cfg_req;
  logic [NT*DW-1:0]  cfg_coeff;
  logic              cfg_ack;
  logic              cfg_busy;
  logic [DW-1:0]     s_in_tdata;
  logic              s_in_tvalid;
  logic              s_in_tready;
  logic [DW-1:0]     fir_tdata;
  logic              fir_tvalid;
  logic              fir_set_coeffs;
  logic              fir_tready;
  logic [1:0]        state_o;

  fir_coeff_sequencer #(.DATA_W(DW), .NUM_TAPS(NT), .IDLE_TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .cfg_req(cfg_req), .cfg_coeff(cfg_coeff),
    .cfg_ack(cfg_ack), .cfg_busy(cfg_busy), .s_in_tdata(s_in_tdata),
    .s_in_tvalid(s_in_tvalid), .s_in_tready(s_in_tready), .fir_tdata(fir_tdata),
    .fir_tvalid(fir_tvalid), .fir_set_coeffs(fir_set_coeffs),
    .fir_tready(fir_tready), .state_o(state_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int acks = 0;
  int coef_hs = 0;
  int cyc = 0;
  int tap_seen = 0;
  int tready_mode = 0;
  int pat_idx = 0;
  bit auto_drop = 1'b0;
  bit last_ack = 1'b0;
  bit last_in_hs = 1'b0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_taps[NT];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic request(input logic [NT*DW-1:0] c);
    cfg_coeff = c;
    for (int i = 0; i < NT; i++) exp_taps[i] = c[i*DW +: DW];
    cfg_req = 1'b1;
  endtask

  // One clock: sample handshakes before the edge, score them after it
  task automatic tick();
    logic p_valid, p_set, p_tready, p_in_hs, p_rst;
    logic [DW-1:0] p_data, p_in_d;
    if (tready_mode == 1) begin
      fir_tready = (pat_idx % 3 == 0);
      pat_idx++;
    end else if (tready_mode == 2) begin
      fir_tready = 1'($urandom_range(0, 1));
    end
    #2;
    p_valid  = fir_tvalid;
    p_set    = fir_set_coeffs;
    p_data   = fir_tdata;
    p_tready = fir_tready;
    p_in_hs  = s_in_tvalid && s_in_tready;
    p_in_d   = s_in_tdata;
    p_rst    = reset;
    @(posedge clk);
    #1;
    cyc++;
    last_in_hs = 1'b0;
    if (p_rst && reset) begin
      if (p_valid && p_tready) begin
        if (!p_set) begin
          check("sb_sample_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) check("sb_sample", 32'(p_data), 32'(exp_q.pop_front()));
        end else begin
          check("sb_tap_range", 32'(tap_seen < NT), 32'd1);
          if (tap_seen < NT) check("sb_tap", 32'(p_data), 32'(exp_taps[tap_seen]));
          tap_seen++;
          coef_hs++;
        end
      end
      if (p_valid && !p_tready)
        check("stall_hold", 32'({fir_tvalid, fir_set_coeffs, fir_tdata}), 32'({1'b1, p_set, p_data}));
      if (p_in_hs) begin
        check("latency", 32'({fir_tvalid, fir_set_coeffs, fir_tdata}), 32'({1'b1, 1'b0, p_in_d}));
        exp_q.push_back(p_in_d);
        last_in_hs = 1'b1;
      end
      if (cfg_ack) begin
        check("ack_taps", 32'(tap_seen), 32'(NT));
        tap_seen = 0;
        acks++;
      end
    end
    check("busy_decode", 32'(cfg_busy), 32'(state_o == 2'b10 || state_o == 2'b11));
    if (fir_set_coeffs) check("set_only_in_load", 32'(state_o), 32'd3);
    if (cfg_busy) check("tready_when_busy", 32'(s_in_tready), 32'd0);
    last_ack = cfg_ack;
    if (auto_drop && cfg_req && state_o == 2'b11) begin
      cfg_req   = 1'b0;
      cfg_coeff = (NT*DW)'($urandom);
    end
  endtask

  task automatic wait_ack(input int limit);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (last_ack) begin
        seen = 1'b1;
        break;
      end
    end
    check("ack_timeout", 32'(seen), 32'd1);
  endtask

  task automatic send_sample(input logic [DW-1:0] v);
    s_in_tvalid = 1'b1;
    s_in_tdata  = v;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (last_in_hs) break;
    end
    check("sample_accept_timeout", 32'(last_in_hs), 32'd1);
    s_in_tvalid = 1'b0;
  endtask

  initial begin
    int first_cyc;
    int acks0;
    int hs0;
    logic [NT*DW-1:0] c;

    reset = 1'b1; cfg_req = 1'b0; cfg_coeff = '0; s_in_tdata = '0;
    s_in_tvalid = 1'b0; fir_tready = 1'b0;

    // 1: asynchronous reset mid-cycle
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_tvalid", 32'(fir_tvalid), 32'd0);
    check("rst_set", 32'(fir_set_coeffs), 32'd0);
    check("rst_tdata", 32'(fir_tdata), 32'd0);
    check("rst_ack", 32'(cfg_ack), 32'd0);
    check("rst_busy", 32'(cfg_busy), 32'd0);
    check("rst_tready", 32'(s_in_tready), 32'd0);
    tick(); tick();
    reset = 1'b1;
    tick();
    check("post_rst_idle", 32'(state_o), 32'd0);

    // 2: stream -1,0,5,-32 back-to-back, then 8 idle cycles to IDLE
    fir_tready = 1'b1;
    send_sample(6'h3f);
    first_cyc = cyc;
    send_sample(6'h00);
    send_sample(6'h05);
    send_sample(6'h20);
    check("stream_b2b", 32'(cyc - first_cyc), 32'd3);
    check("stream_last", 32'({fir_tvalid, fir_set_coeffs, fir_tdata}), 32'({1'b1, 1'b0, 6'h20}));
    for (int i = 0; i < 7; i++) tick();
    check("timeout_7", 32'(state_o), 32'd1);
    tick();
    check("timeout_8", 32'(state_o), 32'd0);

    // 3: load from IDLE; cfg_coeff scrambled once LOAD starts
    auto_drop = 1'b1;
    request({6'd4, 6'd3, 6'd2, 6'd1});
    tick();
    for (int k = 0; k < NT; k++) begin
      check("load_beat", 32'({fir_tvalid, fir_set_coeffs, fir_tdata}), 32'({1'b1, 1'b1, 6'(k + 1)}));
      check("load_state", 32'(state_o), 32'd3);
      tick();
    end
    check("load_ack", 32'(cfg_ack), 32'd1);
    check("load_done", 32'({fir_tvalid, fir_set_coeffs, state_o}), 32'd0);
    tick();
    check("ack_pulse", 32'(cfg_ack), 32'd0);

    // 4: load mid-stream while sample 7 is stalled
    send_sample(6'd10);
    tick();
    fir_tready = 1'b0;
    send_sample(6'd7);
    request(24'($urandom));
    s_in_tvalid = 1'b1;
    s_in_tdata  = 6'd9;
    #1;
    check("tready_on_req", 32'(s_in_tready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("drain_hold", 32'({state_o, fir_tvalid, fir_set_coeffs, fir_tdata}), 32'({2'b10, 1'b1, 1'b0, 6'd7}));
    end
    fir_tready = 1'b1;
    tick();
    check("drain_to_load", 32'({state_o, fir_set_coeffs, fir_tdata}), 32'({2'b11, 1'b1, exp_taps[0]}));
    wait_ack(20);
    check("resume_stream", 32'(state_o), 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      if (last_in_hs) break;
    end
    check("resume_accept", 32'(last_in_hs), 32'd1);
    s_in_tvalid = 1'b0;
    tick(); tick();
    check("no_lost_sample", 32'(exp_q.size()), 32'd0);

    // 5: backpressure 1,0,0 during load
    acks0 = acks;
    hs0 = coef_hs;
    tready_mode = 1;
    pat_idx = 0;
    request(24'($urandom));
    wait_ack(60);
    tready_mode = 0;
    fir_tready = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    check("bp_one_ack", 32'(acks - acks0), 32'd1);
    check("bp_four_beats", 32'(coef_hs - hs0), 32'd4);

    // cfg_req held through ack starts a second load
    auto_drop = 1'b0;
    request(24'($urandom));
    wait_ack(20);
    tick();
    check("reload_held", 32'({state_o, fir_set_coeffs, fir_tdata}), 32'({2'b11, 1'b1, exp_taps[0]}));
    cfg_req = 1'b0;
    wait_ack(20);
    auto_drop = 1'b1;
    tick();

    // 6: reset after the 2nd coefficient beat
    acks0 = acks;
    request(24'($urandom));
    tick(); tick(); tick();
    #2 reset = 1'b0;
    #1;
    check("rst_mid_load", 32'({state_o, fir_tvalid, fir_set_coeffs, cfg_ack}), 32'd0);
    tap_seen = 0;
    cfg_req = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    check("rst_load_idle", 32'(state_o), 32'd0);
    check("rst_load_no_ack", 32'(acks - acks0), 32'd0);
    c = 24'($urandom);
    request(c);
    tick();
    check("reload_tap0", 32'({fir_set_coeffs, fir_tdata}), 32'({1'b1, c[DW-1:0]}));
    wait_ack(20);

    // Random traffic against the scoreboard
    tready_mode = 2;
    for (int n = 0; n < 400; n++) begin
      s_in_tvalid = 1'($urandom_range(0, 1));
      s_in_tdata  = DW'($urandom);
      if (!cfg_req && (state_o == 2'b00 || state_o == 2'b01) && $urandom_range(0, 19) == 0)
        request(24'($urandom));
      tick();
    end
    tready_mode = 0;
    fir_tready = 1'b1;
    s_in_tvalid = 1'b0;
    for (int i = 0; i < 30; i++) tick();
    check("rand_queue_empty", 32'(exp_q.size()), 32'd0);
    check("rand_no_partial_load", 32'(tap_seen), 32'd0);
    check("rand_final_idle", 32'(state_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
